// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register for the 16-bit five-stage pipeline.
// Captures EX results and control on each load edge, holds on stall,
// inserts bubbles on flush, and latches a sticky HALT so nothing younger
// than HALT reaches MEM or the forwarding unit.
// Optional feature macro: EXMEM_BUBBLE_COUNT_EN enables the saturating
// bubble counter; without it bubble_count is tied to zero.
module ex_mem_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_comp_result,
  input  logic [15:0] ex_slbi_result,
  input  logic [15:0] ex_immediate,
  input  logic [15:0] ex_pc_add,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_write_r,
  input  logic        ex_REG_WRITE,
  input  logic        ex_MEM_READ,
  input  logic        ex_MEM_WRITE,
  input  logic        ex_COMP_REG,
  input  logic        ex_SLBI,
  input  logic        ex_LBI,
  input  logic        ex_JUMP,
  input  logic        ex_HALT,
  output logic [15:0] mem_alu_out,
  output logic [15:0] mem_comp_result,
  output logic [15:0] mem_slbi_result,
  output logic [15:0] mem_immediate,
  output logic [15:0] mem_pc_add,
  output logic [15:0] mem_store_data,
  output logic [2:0]  mem_write_r,
  output logic        mem_REG_WRITE,
  output logic        mem_MEM_READ,
  output logic        mem_MEM_WRITE,
  output logic        mem_COMP_REG,
  output logic        mem_SLBI,
  output logic        mem_LBI,
  output logic        mem_JUMP,
  output logic        mem_HALT,
  output logic        mem_valid,
  output logic        mem_halted,
  output logic [15:0] bubble_count
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_bubble;
  logic   w_count;

  logic [15:0] r_alu_out, r_comp_result, r_slbi_result;
  logic [15:0] r_immediate, r_pc_add, r_store_data;
  logic [2:0]  r_write_r;
  logic [7:0]  r_ctl;
  logic        r_valid;
  logic [7:0]  w_ex_ctl;

  // Control bits gathered in output order so they can be gated as one vector.
  assign w_ex_ctl = {ex_REG_WRITE, ex_MEM_READ, ex_MEM_WRITE, ex_COMP_REG,
                     ex_SLBI, ex_LBI, ex_JUMP, ex_HALT};

  // Sticky RUN/HALTED state; only reset returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Edge-action decode: flush beats stall; a load while HALTED becomes a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_count     = 1'b0;
    if (flush) begin
      w_bubble = 1'b1;
      w_count  = 1'b1;
    end else if (!stall) begin
      case (r_state)
        S_RUN: begin
          w_load  = 1'b1;
          w_count = !ex_valid;
          if (ex_valid && ex_HALT) w_state_nxt = S_HALTED;
        end
        S_HALTED: begin
          w_bubble = 1'b1;
          w_count  = 1'b1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Data fields: captured on load only; bubbles leave them untouched to avoid toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out     <= '0;
      r_comp_result <= '0;
      r_slbi_result <= '0;
      r_immediate   <= '0;
      r_pc_add      <= '0;
      r_store_data  <= '0;
      r_write_r     <= '0;
    end else if (w_load) begin
      r_alu_out     <= ex_alu_out;
      r_comp_result <= ex_comp_result;
      r_slbi_result <= ex_slbi_result;
      r_immediate   <= ex_immediate;
      r_pc_add      <= ex_pc_add;
      r_store_data  <= ex_store_data;
      r_write_r     <= ex_write_r;
    end
  end

  // Valid and control: cleared on bubble, gated by ex_valid on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl   <= '0;
      r_valid <= 1'b0;
    end else if (w_bubble) begin
      r_ctl   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_ctl   <= w_ex_ctl & {8{ex_valid}};
      r_valid <= ex_valid;
    end
  end

`ifdef EXMEM_BUBBLE_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_bubble_count;

  // Saturating count of bubble edges and invalid RUN loads.
  always_ff @(posedge clk) begin
    if (rst)          r_bubble_count <= '0;
    else if (w_count) r_bubble_count <= sat_inc16(r_bubble_count);
  end

  assign bubble_count = r_bubble_count;
`else
  logic w_unused_count;
  assign w_unused_count = w_count;
  assign bubble_count   = 16'd0;
`endif

  assign mem_alu_out     = r_alu_out;
  assign mem_comp_result = r_comp_result;
  assign mem_slbi_result = r_slbi_result;
  assign mem_immediate   = r_immediate;
  assign mem_pc_add      = r_pc_add;
  assign mem_store_data  = r_store_data;
  assign mem_write_r     = r_write_r;
  assign mem_REG_WRITE   = r_ctl[7];
  assign mem_MEM_READ    = r_ctl[6];
  assign mem_MEM_WRITE   = r_ctl[5];
  assign mem_COMP_REG    = r_ctl[4];
  assign mem_SLBI        = r_ctl[3];
  assign mem_LBI         = r_ctl[2];
  assign mem_JUMP        = r_ctl[1];
  assign mem_HALT        = r_ctl[0];
  assign mem_valid       = r_valid;
  assign mem_halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: directed scenarios plus randomized
// traffic compared against a rule-level reference model of the MEM bundle.
module tb_ex_mem_latch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
  logic [15:0] ex_alu_out = '0, ex_comp_result = '0, ex_slbi_result = '0;
  logic [15:0] ex_immediate = '0, ex_pc_add = '0, ex_store_data = '0;
  logic [2:0]  ex_write_r = '0;
  logic [7:0]  ex_ctl = '0; // REG_WRITE,MEM_READ,MEM_WRITE,COMP_REG,SLBI,LBI,JUMP,HALT

  logic [15:0] mem_alu_out, mem_comp_result, mem_slbi_result;
  logic [15:0] mem_immediate, mem_pc_add, mem_store_data, bubble_count;
  logic [2:0]  mem_write_r;
  logic mem_REG_WRITE, mem_MEM_READ, mem_MEM_WRITE, mem_COMP_REG;
  logic mem_SLBI, mem_LBI, mem_JUMP, mem_HALT, mem_valid, mem_halted;

  ex_mem_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(ex_alu_out), .ex_comp_result(ex_comp_result),
    .ex_slbi_result(ex_slbi_result), .ex_immediate(ex_immediate),
    .ex_pc_add(ex_pc_add), .ex_store_data(ex_store_data), .ex_write_r(ex_write_r),
    .ex_REG_WRITE(ex_ctl[7]), .ex_MEM_READ(ex_ctl[6]), .ex_MEM_WRITE(ex_ctl[5]),
    .ex_COMP_REG(ex_ctl[4]), .ex_SLBI(ex_ctl[3]), .ex_LBI(ex_ctl[2]),
    .ex_JUMP(ex_ctl[1]), .ex_HALT(ex_ctl[0]),
    .mem_alu_out(mem_alu_out), .mem_comp_result(mem_comp_result),
    .mem_slbi_result(mem_slbi_result), .mem_immediate(mem_immediate),
    .mem_pc_add(mem_pc_add), .mem_store_data(mem_store_data),
    .mem_write_r(mem_write_r),
    .mem_REG_WRITE(mem_REG_WRITE), .mem_MEM_READ(mem_MEM_READ),
    .mem_MEM_WRITE(mem_MEM_WRITE), .mem_COMP_REG(mem_COMP_REG),
    .mem_SLBI(mem_SLBI), .mem_LBI(mem_LBI), .mem_JUMP(mem_JUMP), .mem_HALT(mem_HALT),
    .mem_valid(mem_valid), .mem_halted(mem_halted), .bubble_count(bubble_count)
  );

  // Reference model state: what MEM should be showing.
  logic [95:0] m_data;    // alu, comp, slbi, imm, pc, store
  logic [2:0]  m_wr;
  logic [7:0]  m_ctl;
  logic        m_valid, m_halted;
  int          m_bubbles; // unsaturated count of bubble-worthy edges

  int n_pass = 0;
  int n_checks = 0;

  function automatic logic [15:0] exp_count();
`ifdef EXMEM_BUBBLE_COUNT_EN
    return (m_bubbles > 65535) ? 16'hFFFF : m_bubbles[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // One clock edge of behaviour, written from the edge-action priority rules.
  task automatic model_edge();
    if (rst) begin
      m_data = '0; m_wr = '0; m_ctl = '0; m_valid = 0; m_halted = 0; m_bubbles = 0;
    end else if (flush || (!stall && m_halted)) begin
      m_ctl = '0; m_valid = 0; m_bubbles++;
    end else if (!stall) begin
      m_data  = {ex_alu_out, ex_comp_result, ex_slbi_result,
                 ex_immediate, ex_pc_add, ex_store_data};
      m_wr    = ex_write_r;
      m_valid = ex_valid;
      m_ctl   = ex_valid ? ex_ctl : 8'h00;
      if (!ex_valid) m_bubbles++;
      if (ex_valid && ex_ctl[0]) m_halted = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data"}, {32'h0, mem_alu_out, mem_comp_result, mem_slbi_result,
        mem_immediate, mem_pc_add, mem_store_data}, {32'h0, m_data});
    chk({tag, ".wr"}, 128'(mem_write_r), 128'(m_wr));
    chk({tag, ".ctl"}, 128'({mem_REG_WRITE, mem_MEM_READ, mem_MEM_WRITE, mem_COMP_REG,
        mem_SLBI, mem_LBI, mem_JUMP, mem_HALT}), 128'(m_ctl));
    chk({tag, ".vld_halt"}, 128'({mem_valid, mem_halted}), 128'({m_valid, m_halted}));
    chk({tag, ".cnt"}, 128'(bubble_count), 128'(exp_count()));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic load_ex(input logic v, input logic [15:0] alu, input logic [2:0] wr,
                         input logic [7:0] ctl);
    ex_valid = v; ex_alu_out = alu; ex_write_r = wr; ex_ctl = ctl;
  endtask

  initial begin
    m_data = '0; m_wr = '0; m_ctl = '0; m_valid = 0; m_halted = 0; m_bubbles = 0;

    // Reset state
    rst = 1; tick("reset"); tick("reset2");
    chk("reset.alu", 128'(mem_alu_out), 128'h0);
    rst = 0;

    // Scenario 1: basic load
    load_ex(1, 16'h1234, 3'd5, 8'h80);
    tick("s1");
    chk("s1.alu", 128'(mem_alu_out), 128'h1234);
    chk("s1.wr_rw_v", 128'({mem_write_r, mem_REG_WRITE, mem_valid}), 128'({3'd5, 2'b11}));

    // Scenario 2: stall 3 cycles, then load
    load_ex(1, 16'hBEEF, 3'd2, 8'h80); stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick("s2.stall");
      chk("s2.hold", 128'({mem_alu_out, mem_write_r, mem_REG_WRITE}),
          128'({16'h1234, 3'd5, 1'b1}));
    end
    stall = 0; tick("s2.load");
    chk("s2.loaded", 128'(mem_alu_out), 128'hBEEF);

    // Scenario 3: flush with stall
    load_ex(1, 16'h00AA, 3'd3, 8'hFE); tick("s3.pre");
    flush = 1; stall = 1; ex_alu_out = 16'h5555; tick("s3.flush");
    chk("s3.bubble", 128'({mem_alu_out, mem_valid, mem_REG_WRITE, mem_JUMP}),
        128'({16'h00AA, 3'b000}));
    flush = 0; stall = 0;

    // Scenario 4: invalid slot gates control
    load_ex(0, 16'h0777, 3'd1, 8'hC0); tick("s4");
    chk("s4.gate", 128'({mem_REG_WRITE, mem_MEM_READ, mem_valid}), 128'(3'b000));

    // Scenario 5: HALT then younger ADD, then reset
    load_ex(1, 16'h0001, 3'd0, 8'h01); tick("s5.halt");
    chk("s5.h", 128'({mem_HALT, mem_halted}), 128'(2'b11));
    load_ex(1, 16'h0002, 3'd4, 8'h80); tick("s5.add");
    chk("s5.blocked", 128'({mem_valid, mem_REG_WRITE, mem_halted}), 128'(3'b001));
    stall = 1; tick("s5.stall"); stall = 0;
    rst = 1; tick("s5.rst");
    chk("s5.zero", 128'({mem_alu_out, mem_write_r, mem_valid, mem_halted, mem_HALT}), 128'h0);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 6) == 0);
      ex_valid = ($urandom_range(0, 4) != 0);
      ex_alu_out = 16'($urandom); ex_comp_result = 16'($urandom);
      ex_slbi_result = 16'($urandom); ex_immediate = 16'($urandom);
      ex_pc_add = 16'($urandom); ex_store_data = 16'($urandom);
      ex_write_r = 3'($urandom);
      ex_ctl = {7'($urandom), ($urandom_range(0, 24) == 0)};
      tick("rand");
    end

`ifdef EXMEM_BUBBLE_COUNT_EN
    // Scenario 6: counter saturation
    rst = 1; stall = 0; flush = 0; tick("s6.rst"); rst = 0;
    flush = 1;
    for (int i = 0; i < 16'hFFFE; i++) begin
      @(posedge clk); model_edge();
    end
    #1;
    chk("s6.fffe", 128'(bubble_count), 128'hFFFE);
    for (int i = 0; i < 3; i++) tick("s6.sat");
    chk("s6.ffff", 128'(bubble_count), 128'hFFFF);
    flush = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

EX/MEM pipeline register for the 16-bit five-stage pipeline. It captures every EX-stage result candidate and control bit at the clock edge and presents them as the `mem_*` bundle. That bundle is consumed by the MEM stage and by the forwarding unit, which uses it for MEM-stage write-data selection and register-match detection. The register holds the bundle on stall, inserts bubbles on flush, and latches a sticky halt so that no instruction younger than HALT ever becomes visible downstream.

## Interface
Parameters:
- none. All widths are fixed: 16-bit data, 3-bit register index.

Ports:
- `clk`  in  1  pipeline clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all contents; from the hazard unit or a memory wait.
- `flush`  in  1  load a bubble this edge; from branch/jump resolution.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_alu_out`, `ex_comp_result`, `ex_slbi_result`, `ex_immediate`, `ex_pc_add`, `ex_store_data`  in  16 each  EX data fields.
- `ex_write_r`  in  3  destination register.
- `ex_REG_WRITE`, `ex_MEM_READ`, `ex_MEM_WRITE`, `ex_COMP_REG`, `ex_SLBI`, `ex_LBI`, `ex_JUMP`, `ex_HALT`  in  1 each  EX control bits.
- `mem_alu_out`, `mem_comp_result`, `mem_slbi_result`, `mem_immediate`, `mem_pc_add`, `mem_store_data`  out  16 each  registered data fields.
- `mem_write_r`  out  3  registered destination register.
- `mem_REG_WRITE`, `mem_MEM_READ`, `mem_MEM_WRITE`, `mem_COMP_REG`, `mem_SLBI`, `mem_LBI`, `mem_JUMP`, `mem_HALT`  out  1 each  registered control bits.
- `mem_valid`  out  1  MEM holds a real instruction.
- `mem_halted`  out  1  sticky: a HALT has been captured.
- `bubble_count`  out  16  number of bubbles inserted (see Configuration).

## Operation
The block has two states, RUN and HALTED, encoded by `mem_halted`.

Edge actions, in priority order:
1. `rst`: reset action. Every output becomes 0 and the state becomes RUN.
2. `flush`: bubble action, even if `stall` is also asserted.
3. `stall`: hold action. Every output keeps its value.
4. Otherwise: load action.

Bubble action:
- `mem_valid` and all eight control outputs become 0.
- Data fields and `mem_write_r` keep their previous values (no toggling).

Load action in RUN:
- All data fields and `mem_write_r` capture their `ex_*` inputs.
- `mem_valid` captures `ex_valid`.
- Each control output captures `ex_<bit> & ex_valid`, so an invalid EX slot can never assert `mem_REG_WRITE` toward the forwarding unit.

HALT capture:
- A load with `ex_valid & ex_HALT` moves the state to HALTED on the same edge.
- `mem_halted` is therefore 1 in the same cycle that `mem_HALT` is 1.

Load action in HALTED:
- Performed as a bubble action.
- Only `rst` leaves HALTED.

`stall` while HALTED holds, as in RUN.

## Timing
- Latency: exactly 1 cycle from `ex_*` to `mem_*` on a load edge.
- No combinational path from any input to any output; all outputs are flop-driven.
- `stall` held for N cycles freezes outputs for N cycles. The load occurs on the first edge with `stall=0`.
- A `flush` pulse of one cycle produces exactly one bubble.
- `flush` and `stall` asserted together produce a bubble. The EX-side stall is the hazard unit's responsibility.
- `rst` asserted mid-stream (including while stalled or HALTED) clears the block on that edge. The first load is permitted on the first edge after `rst` deasserts.

## Configuration
Macro: `EXMEM_BUBBLE_COUNT_EN`.

Defined:
- `bubble_count` increments by 1 on each bubble action, whether caused by `flush` or by a load in HALTED.
- It also increments on each RUN load with `ex_valid=0`.
- It does not increment on stall edges.
- It saturates at 0xFFFF and resets to 0.

Undefined:
- The counter logic is omitted and `bubble_count` is tied to 0.
- The port remains present so the top-level netlist is unchanged.

## Test plan
1. Reset, then load `ex_valid=1`, `ex_alu_out=0x1234`, `ex_write_r=5`, `ex_REG_WRITE=1` -> next cycle `mem_alu_out=0x1234`, `mem_write_r=5`, `mem_REG_WRITE=1`, `mem_valid=1`.
2. After scenario 1, assert `stall` for 3 cycles while `ex_alu_out=0xBEEF` -> outputs remain 0x1234/5/1 for 3 cycles. The fourth edge loads 0xBEEF.
3. `flush=1` with `stall=1`, prior `mem_alu_out=0x00AA` -> `mem_valid=0`, all control bits 0, `mem_alu_out` stays 0x00AA. With the macro defined, `bubble_count` 0 -> 1.
4. Load `ex_valid=0`, `ex_REG_WRITE=1`, `ex_MEM_READ=1` -> `mem_REG_WRITE=0`, `mem_MEM_READ=0`, `mem_valid=0`.
5. Load a valid HALT, then a valid ADD with `ex_REG_WRITE=1` -> cycle 1: `mem_HALT=1`, `mem_halted=1`. Cycle 2: `mem_valid=0`, `mem_REG_WRITE=0`, `mem_halted=1`. Then assert `rst` -> all outputs 0.
6. With the macro defined, preload the counter to 0xFFFE via 0xFFFE flushes, then apply 3 more flushes -> `bubble_count` reads 0xFFFF and holds there.
